// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-flop synchroniser, mid-bit sampling, stop-bit check, 1-cycle valid strobe.
// Define UART_RX_PARITY_EN to receive 8E1 frames and report parity_err.
module uart_rx #(
    parameter int unsigned CLOCK_DIV = 1250
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       rx,
    output logic [7:0] data_out,
    output logic       valid,
    output logic       busy,
    output logic       frame_err,
    output logic       parity_err
);

    // Output handshake: valid is a one-cycle strobe with no ready; data_out is
    // updated in the same cycle and holds until the next good frame, so the
    // consumer must take it before the following valid.

    localparam logic [15:0] BIT_LAST  = 16'(CLOCK_DIV - 1);
    localparam logic [15:0] HALF_LAST = 16'((CLOCK_DIV / 2) - 1);

`ifdef UART_RX_PARITY_EN
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;
`else
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd4
    } state_t;
`endif

    state_t      state, state_nx;
    logic        rx_meta, rx_s, rx_s_d;
    logic [15:0] clock_count, count_nx;
    logic [2:0]  bit_idx, bit_idx_nx;
    logic [7:0]  shift, shift_nx;
    logic [7:0]  data_nx;
    logic        valid_nx;
    logic        frame_err_nx;

    // Synchroniser resets to the idle-high level so reset never fakes a start edge.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
            rx_s_d  <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
            rx_s_d  <= rx_s;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            clock_count <= '0;
            bit_idx     <= '0;
            shift       <= '0;
            data_out    <= '0;
            valid       <= 1'b0;
            frame_err   <= 1'b0;
        end else begin
            state       <= state_nx;
            clock_count <= count_nx;
            bit_idx     <= bit_idx_nx;
            shift       <= shift_nx;
            data_out    <= data_nx;
            valid       <= valid_nx;
            frame_err   <= frame_err_nx;
        end
    end

`ifdef UART_RX_PARITY_EN
    // par_bad holds this frame's parity result until the stop bit proves the frame good.
    logic par_bad, par_bad_nx, parity_err_nx;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            par_bad    <= 1'b0;
            parity_err <= 1'b0;
        end else begin
            par_bad    <= par_bad_nx;
            parity_err <= parity_err_nx;
        end
    end
`else
    assign parity_err = 1'b0;
`endif

    always_comb begin
        state_nx     = state;
        count_nx     = clock_count;
        bit_idx_nx   = bit_idx;
        shift_nx     = shift;
        data_nx      = data_out;
        valid_nx     = 1'b0;
        frame_err_nx = frame_err;
`ifdef UART_RX_PARITY_EN
        par_bad_nx    = par_bad;
        parity_err_nx = parity_err;
`endif
        case (state)
            IDLE: begin
                count_nx = '0;
                // Falling edge only: a line held low never retriggers.
                if (rx_s_d && !rx_s) state_nx = START;
            end
            START: begin
                if (clock_count == HALF_LAST) begin
                    count_nx   = '0;
                    bit_idx_nx = '0;
                    state_nx   = rx_s ? IDLE : DATA;
                end else begin
                    count_nx = clock_count + 16'd1;
                end
            end
            DATA: begin
                if (clock_count == BIT_LAST) begin
                    count_nx          = '0;
                    shift_nx[bit_idx] = rx_s;
                    if (bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_nx = PARITY;
`else
                        state_nx = STOP;
`endif
                    end else begin
                        bit_idx_nx = bit_idx + 3'd1;
                    end
                end else begin
                    count_nx = clock_count + 16'd1;
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (clock_count == BIT_LAST) begin
                    count_nx   = '0;
                    par_bad_nx = rx_s ^ (^shift);
                    state_nx   = STOP;
                end else begin
                    count_nx = clock_count + 16'd1;
                end
            end
`endif
            STOP: begin
                if (clock_count == BIT_LAST) begin
                    count_nx = '0;
                    state_nx = IDLE;
                    if (rx_s) begin
                        data_nx      = shift;
                        valid_nx     = 1'b1;
                        frame_err_nx = 1'b0;
`ifdef UART_RX_PARITY_EN
                        parity_err_nx = par_bad;
`endif
                    end else begin
                        frame_err_nx = 1'b1;
                    end
                end else begin
                    count_nx = clock_count + 16'd1;
                end
            end
            default: begin
                state_nx = IDLE;
                count_nx = '0;
            end
        endcase
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at CLOCK_DIV=16: framing, glitch, frame error, reset, optional parity.
module tb_uart_rx;

    localparam int DIV = 16;
`ifdef UART_RX_PARITY_EN
    localparam int PAR_BITS = 1;
`else
    localparam int PAR_BITS = 0;
`endif
    localparam int LAT_NOM = 2 + DIV / 2 + 9 * DIV + PAR_BITS * DIV;

    logic       clock = 1'b0;
    logic       reset_n;
    logic       rx = 1'b1;
    logic [7:0] data_out;
    logic       valid, busy, frame_err, parity_err;

    uart_rx #(.CLOCK_DIV(DIV)) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .rx         (rx),
        .data_out   (data_out),
        .valid      (valid),
        .busy       (busy),
        .frame_err  (frame_err),
        .parity_err (parity_err)
    );

    // clock / reset
    always #5 clock = ~clock;

    int         n_checks = 0;
    int         n_fail = 0;
    int         cyc = 0;
    int         vcount = 0;
    int         last_valid_cyc = 0;
    int         start_cyc = 0;
    logic       track_gap = 1'b0;
    int         gap_run = 0;
    int         max_gap = 0;
    logic       par_flip = 1'b0;
    logic [7:0] exp_q[$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    always @(posedge clock) cyc++;

    // scoreboard: every valid strobe must match the next expected byte
    always @(negedge clock) begin
        if (reset_n === 1'b1 && valid === 1'b1) begin
            vcount++;
            last_valid_cyc = cyc;
            check_eq("valid_expected", 32'(exp_q.size() != 0), 1);
            if (exp_q.size() != 0) check_eq("data_out", 32'(data_out), 32'(exp_q.pop_front()));
        end
    end

    always @(negedge clock) begin
        if (track_gap) begin
            if (!busy) gap_run++;
            else begin
                if (gap_run > max_gap) max_gap = gap_run;
                gap_run = 0;
            end
        end
    end

    // driver tasks (called at a negedge)
    task automatic wait_clk(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic drive_bit(input logic b);
        rx = b;
        repeat (DIV) @(negedge clock);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_bit);
        start_cyc = cyc;
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(b[i]);
`ifdef UART_RX_PARITY_EN
        drive_bit((^b) ^ par_flip);
`endif
        drive_bit(stop_bit);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, idle_at, v0;
        logic saw_busy;

        reset_n = 1'b1;
        #2 reset_n = 1'b0;
        wait_clk(3);
        check_eq("rst_data_out", 32'(data_out), 0);
        check_eq("rst_valid", 32'(valid), 0);
        check_eq("rst_busy", 32'(busy), 0);
        check_eq("rst_frame_err", 32'(frame_err), 0);
        check_eq("rst_parity_err", 32'(parity_err), 0);
        reset_n = 1'b1;
        wait_clk(20);

        // 1: single frame, latency window
        exp_q.push_back(8'hA5);
        send_frame(8'hA5, 1'b1);
        wait_clk(4);
        lat = last_valid_cyc - start_cyc;
        check_eq("t1_latency_in_window", 32'(lat >= LAT_NOM - 1 && lat <= LAT_NOM + 1), 1);
        check_eq("t1_valid_cycles", 32'(vcount), 1);
        check_eq("t1_frame_err", 32'(frame_err), 0);
        check_eq("t1_data_out", 32'(data_out), 32'h A5);

        // 2: back-to-back frames
        wait_clk(20);
        exp_q.push_back(8'h3C);
        exp_q.push_back(8'hC3);
        send_frame(8'h3C, 1'b1);
        track_gap = 1'b1;
        send_frame(8'hC3, 1'b1);
        track_gap = 1'b0;
        wait_clk(4);
        check_eq("t2_valid_cycles", 32'(vcount), 3);
        check_eq("t2_gap_nonzero", 32'(max_gap >= 1), 1);
        check_eq("t2_gap_le_div", 32'(max_gap <= DIV), 1);
        check_eq("t2_data_out", 32'(data_out), 32'h C3);

        // 3: 4-clock glitch
        wait_clk(20);
        saw_busy = 1'b0;
        idle_at = 0;
        rx = 1'b0;
        for (int i = 1; i <= 16; i++) begin
            if (i == 5) rx = 1'b1;
            @(negedge clock);
            if (busy) saw_busy = 1'b1;
            else if (saw_busy && idle_at == 0) idle_at = i;
        end
        check_eq("t3_busy_rose", 32'(saw_busy), 1);
        check_eq("t3_idle_by_12", 32'(idle_at > 0 && idle_at <= 12), 1);
        check_eq("t3_no_valid", 32'(vcount), 3);
        check_eq("t3_frame_err", 32'(frame_err), 0);

        // 4: bad stop bit, held-low line, recovery
        wait_clk(20);
        send_frame(8'h55, 1'b0);
        check_eq("t4_frame_err_set", 32'(frame_err), 1);
        check_eq("t4_data_kept", 32'(data_out), 32'h C3);
        wait_clk(40);
        check_eq("t4_no_retrigger", 32'(busy), 0);
        check_eq("t4_no_valid", 32'(vcount), 3);
        rx = 1'b1;
        wait_clk(DIV);
        exp_q.push_back(8'h12);
        send_frame(8'h12, 1'b1);
        wait_clk(4);
        check_eq("t4_frame_err_clear", 32'(frame_err), 0);
        check_eq("t4_valid_cycles", 32'(vcount), 4);

        // 5: reset at bit 4 of a frame
        wait_clk(20);
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(1'b1);
        rx = 1'b0;
        wait_clk(DIV / 2);
        check_eq("t5_busy_mid_frame", 32'(busy), 1);
        #2 reset_n = 1'b0;
        #1;
        check_eq("t5_rst_data_out", 32'(data_out), 0);
        check_eq("t5_rst_busy", 32'(busy), 0);
        check_eq("t5_rst_valid", 32'(valid), 0);
        check_eq("t5_rst_frame_err", 32'(frame_err), 0);
        rx = 1'b1;
        wait_clk(3);
        reset_n = 1'b1;
        wait_clk(20);
        v0 = vcount;
        exp_q.push_back(8'hFF);
        send_frame(8'hFF, 1'b1);
        wait_clk(4);
        check_eq("t5_data_ff", 32'(data_out), 32'h FF);
        check_eq("t5_one_valid", 32'(vcount - v0), 1);

`ifdef UART_RX_PARITY_EN
        // 6: parity good then bad
        wait_clk(20);
        par_flip = 1'b0;
        exp_q.push_back(8'h07);
        send_frame(8'h07, 1'b1);
        wait_clk(4);
        check_eq("t6_parity_ok", 32'(parity_err), 0);
        par_flip = 1'b1;
        exp_q.push_back(8'h07);
        send_frame(8'h07, 1'b1);
        wait_clk(4);
        check_eq("t6_parity_bad", 32'(parity_err), 1);
        check_eq("t6_valid_cycles", 32'(vcount - v0), 3);
        par_flip = 1'b0;
`else
        check_eq("parity_err_tied", 32'(parity_err), 0);
`endif

        check_eq("scoreboard_drained", 32'(exp_q.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
